// File: rtl/genius_if.sv
// Button/status bundle between the IR decoder side and the Genius game sequencer.
// The decoder (master) drives the event lines; the sequencer (slave) drives LEDs and status.
interface genius_if #(
  parameter int LW = 5
);
  logic          rdy;
  logic          b_power;
  logic          b_blue;
  logic          b_yellow;
  logic          b_green;
  logic          b_red;
  logic [1:0]    color;
  logic [3:0]    led;
  logic [LW-1:0] level;
  logic          busy;
  logic          game_over;
  logic          win;

  modport master (
    output rdy, b_power, b_blue, b_yellow, b_green, b_red, color,
    input  led, level, busy, game_over, win
  );

  modport slave (
    input  rdy, b_power, b_blue, b_yellow, b_green, b_red, color,
    output led, level, busy, game_over, win
  );
endinterface

// File: rtl/genius_game_ctrl.sv
// Simon-style game sequencer: builds a random color sequence, plays it back, checks player input.
// Optional macro GENIUS_TIMEOUT_EN adds an idle timeout (loss) while waiting for player input.
module genius_game_ctrl #(
  parameter int MAX_LEN        = 16,
  parameter int SHOW_CYCLES    = 25000000,
  parameter int GAP_CYCLES     = 12500000,
  parameter int TIMEOUT_CYCLES = 250000000,
  parameter int LW             = $clog2(MAX_LEN + 1)
) (
  input logic     clk,
  input logic     rst,
  genius_if.slave bus
);

  localparam int IW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TMAX = (SHOW_CYCLES > GAP_CYCLES)
                      ? ((SHOW_CYCLES > TIMEOUT_CYCLES) ? SHOW_CYCLES : TIMEOUT_CYCLES)
                      : ((GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES);
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0] SHOW_END = TW'(SHOW_CYCLES - 1);
  localparam logic [TW-1:0] GAP_END  = TW'(GAP_CYCLES - 1);
`ifdef GENIUS_TIMEOUT_EN
  localparam logic [TW-1:0] TO_END   = TW'(TIMEOUT_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    IDLE, ADD, SHOW_ON, SHOW_OFF, WAIT_IN, GAP, LOSE, WIN
  } state_t;

  state_t        state;
  logic          rdy_q;
  logic [1:0]    seq [MAX_LEN];
  logic [LW-1:0] len;
  logic [IW-1:0] idx;
  logic [TW-1:0] tmr;
  logic [3:0]    led;
  logic          busy;
  logic          game_over;
  logic          win;

  function automatic logic [3:0] onehot(input logic [1:0] c);
    return 4'b0001 << c;
  endfunction

  // {valid, code}; blue > yellow > green > red
  function automatic logic [2:0] pick_color(input logic bl, input logic ye,
                                            input logic gr, input logic rd);
    if (bl)      return 3'b1_00;
    else if (ye) return 3'b1_01;
    else if (gr) return 3'b1_10;
    else if (rd) return 3'b1_11;
    else         return 3'b0_00;
  endfunction

  logic       ev;
  logic       power_ev;
  logic       color_ev;
  logic [2:0] pick;
  logic       last;
  logic       phase_end;

  assign ev       = bus.rdy & ~rdy_q;
  assign power_ev = ev & bus.b_power;
  assign pick     = pick_color(bus.b_blue, bus.b_yellow, bus.b_green, bus.b_red);
  assign color_ev = ev & ~bus.b_power & pick[2];
  assign last     = (LW'(idx) == len - LW'(1));

  // A timed phase expiring in the same cycle as a power press takes the expiry path.
  assign phase_end = ((state == SHOW_ON) && (tmr == SHOW_END)) ||
                     (((state == SHOW_OFF) || (state == GAP) || (state == WIN)) &&
                      (tmr == GAP_END));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      rdy_q     <= 1'b0;
      len       <= '0;
      idx       <= '0;
      tmr       <= '0;
      led       <= '0;
      busy      <= 1'b0;
      game_over <= 1'b0;
      win       <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) seq[i] <= 2'd0;
    end else begin
      rdy_q <= bus.rdy;
      if (power_ev && !phase_end) begin
        state     <= ADD;
        len       <= '0;
        idx       <= '0;
        tmr       <= '0;
        led       <= '0;
        busy      <= 1'b0;
        game_over <= 1'b0;
        win       <= 1'b0;
      end else begin
        case (state)
          IDLE, LOSE: ;
          ADD: begin
            seq[IW'(len)] <= bus.color;
            len           <= len + LW'(1);
            idx           <= '0;
            tmr           <= '0;
            state         <= SHOW_ON;
            busy          <= 1'b1;
            // seq[0] is only being written now on the very first round
            led           <= onehot((len == '0) ? bus.color : seq[0]);
          end
          SHOW_ON: begin
            if (tmr == SHOW_END) begin
              tmr   <= '0;
              led   <= '0;
              state <= SHOW_OFF;
            end else begin
              tmr <= tmr + TW'(1);
            end
          end
          SHOW_OFF: begin
            if (tmr == GAP_END) begin
              tmr <= '0;
              if (last) begin
                idx   <= '0;
                busy  <= 1'b0;
                state <= WAIT_IN;
              end else begin
                idx   <= idx + IW'(1);
                led   <= onehot(seq[idx + IW'(1)]);
                state <= SHOW_ON;
              end
            end else begin
              tmr <= tmr + TW'(1);
            end
          end
          WAIT_IN: begin
            if (color_ev) begin
              tmr <= '0;
              if (pick[1:0] != seq[idx]) begin
                led       <= 4'b1111;
                game_over <= 1'b1;
                state     <= LOSE;
              end else if (!last) begin
                idx <= idx + IW'(1);
              end else if (len == LW'(MAX_LEN)) begin
                idx   <= '0;
                led   <= 4'b1111;
                win   <= 1'b1;
                state <= WIN;
              end else begin
                idx   <= '0;
                busy  <= 1'b1;
                state <= GAP;
              end
            end
`ifdef GENIUS_TIMEOUT_EN
            else if (tmr == TO_END) begin
              tmr       <= '0;
              led       <= 4'b1111;
              game_over <= 1'b1;
              state     <= LOSE;
            end else begin
              tmr <= tmr + TW'(1);
            end
`endif
          end
          GAP: begin
            if (tmr == GAP_END) begin
              tmr   <= '0;
              busy  <= 1'b0;
              state <= ADD;
            end else begin
              tmr <= tmr + TW'(1);
            end
          end
          WIN: begin
            if (tmr == GAP_END) begin
              tmr <= '0;
              led <= ~led;
            end else begin
              tmr <= tmr + TW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.led       = led;
  assign bus.level     = len;
  assign bus.busy      = busy;
  assign bus.game_over = game_over;
  assign bus.win       = win;

endmodule

// File: tb/tb_genius_game_ctrl.sv
// Randomized bench for genius_game_ctrl against a queue-based game model.
// Honors GENIUS_TIMEOUT_EN the same way the design does.
module tb_genius_game_ctrl;

  localparam int MAX_LEN = 3;
  localparam int SHOW    = 4;
  localparam int GAPC    = 2;
  localparam int TOUT    = 20;
  localparam int LW      = $clog2(MAX_LEN + 1);

  localparam int M_IDLE = 0, M_ADD = 1, M_SHOW = 2, M_DARK = 3,
                 M_WAIT = 4, M_GAP = 5, M_LOSE = 6, M_WIN = 7;
  localparam int P_QUIET = 0, P_PERFECT = 1, P_WRONG = 2, P_RANDOM = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  genius_if #(.LW(LW)) bus();

  genius_game_ctrl #(
    .MAX_LEN(MAX_LEN), .SHOW_CYCLES(SHOW), .GAP_CYCLES(GAPC),
    .TIMEOUT_CYCLES(TOUT), .LW(LW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // reference model of the game
  int   mode;
  int   rem;
  int   pos;
  int   seq_q[$];
  bit   lit;
  bit   rdy_prev;
  bit   saw_win, saw_lose;

  // stimulus drive state
  logic       cur_r;
  logic [4:0] cur_btn;  // {power, blue, yellow, green, red}
  int         hold_left;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] color_bit(input int c);
    return 5'b01000 >> c;
  endfunction

  task automatic model_reset();
    mode = M_IDLE; rem = 0; pos = 0; lit = 0; rdy_prev = 0;
    seq_q.delete();
  endtask

  task automatic model_step(input logic r, input logic [4:0] btn, input logic [1:0] col);
    bit ev, expire;
    int c;
    ev = r && !rdy_prev;
    rdy_prev = r;
    c = btn[3] ? 0 : btn[2] ? 1 : btn[1] ? 2 : btn[0] ? 3 : -1;
    expire = (mode == M_SHOW || mode == M_DARK || mode == M_GAP || mode == M_WIN) && rem == 1;
    if (ev && btn[4] && !expire) begin
      seq_q.delete(); pos = 0; lit = 0; mode = M_ADD;
      return;
    end
    case (mode)
      M_ADD: begin
        seq_q.push_back(int'(col)); pos = 0; mode = M_SHOW; rem = SHOW;
      end
      M_SHOW: if (rem == 1) begin mode = M_DARK; rem = GAPC; end else rem--;
      M_DARK: begin
        if (rem == 1) begin
          if (pos == seq_q.size() - 1) begin pos = 0; mode = M_WAIT; rem = TOUT; end
          else begin pos++; mode = M_SHOW; rem = SHOW; end
        end else rem--;
      end
      M_WAIT: begin
        if (ev && c >= 0) begin
          if (c != seq_q[pos]) mode = M_LOSE;
          else if (pos < seq_q.size() - 1) begin pos++; rem = TOUT; end
          else if (seq_q.size() == MAX_LEN) begin mode = M_WIN; lit = 1; rem = GAPC; end
          else begin mode = M_GAP; rem = GAPC; end
        end
`ifdef GENIUS_TIMEOUT_EN
        else if (rem == 1) mode = M_LOSE;
        else rem--;
`endif
      end
      M_GAP: if (rem == 1) mode = M_ADD; else rem--;
      M_WIN: if (rem == 1) begin lit = !lit; rem = GAPC; end else rem--;
      default: ;
    endcase
  endtask

  task automatic check_outputs();
    logic [3:0] exp_led;
    exp_led = 4'b0000;
    if (mode == M_SHOW) exp_led = 4'(1 << seq_q[pos]);
    else if (mode == M_LOSE) exp_led = 4'b1111;
    else if (mode == M_WIN && lit) exp_led = 4'b1111;
    chk("led", 32'(bus.led), 32'(exp_led));
    chk("level", 32'(bus.level), 32'(seq_q.size()));
    chk("busy", 32'(bus.busy), 32'(mode == M_SHOW || mode == M_DARK || mode == M_GAP));
    chk("game_over", 32'(bus.game_over), 32'(mode == M_LOSE));
    chk("win", 32'(bus.win), 32'(mode == M_WIN));
    if (bus.win === 1'b1) saw_win = 1;
    if (bus.game_over === 1'b1) saw_lose = 1;
  endtask

  task automatic press(input logic [4:0] b, input int hold);
    cur_r = 1'b1; cur_btn = b; hold_left = hold;
  endtask

  task automatic pick_inputs(input int policy);
    logic [4:0] b;
    bit done_mode;
    if (cur_r && hold_left > 0) begin hold_left--; return; end
    if (cur_r) begin cur_r = 1'b0; cur_btn = '0; return; end
    done_mode = (mode == M_IDLE || mode == M_LOSE || mode == M_WIN);
    case (policy)
      P_PERFECT: begin
        if (mode == M_IDLE) press(5'b10000, 0);
        else if (mode == M_WAIT) press(color_bit(seq_q[pos]), int'($urandom % 4));
        else if ($urandom % 8 == 0) press(color_bit(int'($urandom % 4)), 0);
      end
      P_WRONG: begin
        if (done_mode) press(5'b10000, 0);
        else if (mode == M_WAIT) press(color_bit((seq_q[pos] + 1) % 4), 0);
      end
      P_RANDOM: begin
        if ($urandom % 5 == 0) begin
          if (mode == M_WAIT && $urandom % 10 < 7) b = color_bit(seq_q[pos]);
          else begin
            b = 5'($urandom % 32);
            if (b[4] && !done_mode && $urandom % 16 != 0) b[4] = 1'b0;
          end
          press(b, int'($urandom % 3));
        end
      end
      default: ;
    endcase
  endtask

  task automatic cycle(input int policy);
    logic [1:0] col;
    check_outputs();
    pick_inputs(policy);
    col = 2'($urandom % 4);
    bus.rdy = cur_r;
    bus.b_power = cur_btn[4]; bus.b_blue = cur_btn[3]; bus.b_yellow = cur_btn[2];
    bus.b_green = cur_btn[1]; bus.b_red = cur_btn[0];
    bus.color = col;
    model_step(cur_r, cur_btn, col);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int n, input int policy);
    for (int i = 0; i < n; i++) cycle(policy);
  endtask

  task automatic drive_idle();
    cur_r = 1'b0; cur_btn = '0; hold_left = 0;
    bus.rdy = 1'b0; bus.b_power = 1'b0; bus.b_blue = 1'b0; bus.b_yellow = 1'b0;
    bus.b_green = 1'b0; bus.b_red = 1'b0; bus.color = 2'd0;
  endtask

  // Asserts reset between edges, checks the async clear, releases on a falling edge.
  task automatic apply_reset();
    #2 rst = 1'b0;
    drive_idle();
    #1;
    chk("rst_led", 32'(bus.led), 32'd0);
    chk("rst_level", 32'(bus.level), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_game_over", 32'(bus.game_over), 32'd0);
    chk("rst_win", 32'(bus.win), 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    saw_win = 0; saw_lose = 0;
    drive_idle();
    model_reset();
    @(negedge clk);
    apply_reset();
    run(200, P_QUIET);
    run(400, P_PERFECT);
    run(150, P_WRONG);
    // restart then leave WAIT_IN untouched for a long stretch
    cur_r = 1'b0;
    cycle(P_QUIET);
    press(5'b10000, 0);
    bus.rdy = 1'b1;
    run(1000, P_QUIET);
    run(25, P_PERFECT);
    apply_reset();
    run(4000, P_RANDOM);
    run(400, P_PERFECT);
    chk("reached_win", 32'(saw_win), 32'd1);
    chk("reached_lose", 32'(saw_lose), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
